mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width; STRB_WIDTH = DATA_WIDTH/8 (localparam).
REQ-003 Parameter TIMEOUT, default 64, maximum cycles a transaction shall wait for grant plus response.
REQ-004 clk_i  input  1  single clock; all state rising-edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_i[0:1]  input  arb_req_s x2  requester requests {valid, we, addr, wdata, strb}; port 0 = fetch, port 1 = LSU.
REQ-007 rsp_o[0:1]  output  arb_rsp_s x2  requester responses {ready, rvalid, err, rdata}.
REQ-008 mem_req_o  output  arb_mem_req_s  memory request {valid, we, addr, wdata, strb}.
REQ-009 mem_rsp_i  input  arb_mem_rsp_s  memory response {gnt, rvalid, rdata}.
REQ-010 err_o  output  1  sticky protocol-error flag.

Function
REQ-011 FSM states IDLE, ISSUE, WAIT_RSP; exactly one transaction outstanding at a time.
REQ-012 In IDLE, rsp_o[n].ready shall be 1 only for the arbitration winner, combinationally from req_i valids; handshake = valid && ready.
REQ-013 Single valid requester wins; with both valid, winner = port not granted last (round-robin via last_grant register).
REQ-014 On handshake: capture we/addr/wdata/strb and owner id into registers, update last_grant, go to ISSUE.
REQ-015 In ISSUE, mem_req_o.valid = 1 with registered fields held stable; on gnt go to WAIT_RSP.
REQ-016 In WAIT_RSP, on mem_rsp_i.rvalid: rsp_o[owner].rvalid = 1 for exactly one cycle, go to IDLE.
REQ-017 Response rdata = mem rdata for reads, all-zero for writes; rvalid also acts as write acknowledge.
REQ-018 Non-owner rsp_o.rvalid shall stay 0; rdata shall be 0 whenever rvalid = 0.
REQ-019 mem_req_o fields shall be 0 when not in ISSUE.
REQ-020 Minimum latency: handshake cycle N, mem valid N+1, earliest rvalid to requester N+2 (gnt at N+1, rvalid at N+2).
REQ-021 New handshake permitted in the cycle after rvalid (IDLE); no ready during ISSUE or WAIT_RSP.
REQ-022 mem rvalid outside WAIT_RSP, or gnt outside ISSUE: ignored, err_o set to 1.
REQ-023 Timeout counter cleared on handshake, increments each cycle in ISSUE/WAIT_RSP; on reaching TIMEOUT-1 without completion: rsp_o[owner].rvalid = 1, err = 1, rdata = 0, err_o set, go to IDLE.
REQ-024 Timeout and rvalid in same cycle: rvalid wins, err = 0.
REQ-025 err_o clears only on reset.

Reset
REQ-026 Reset forces IDLE, last_grant = 1 (port 0 wins first tie), counter = 0, err_o = 0, all outputs 0.
REQ-027 Reset mid-transaction abandons it; no response is ever delivered for it.

Structure
REQ-028 arb_req_s, arb_rsp_s, arb_mem_req_s, arb_mem_rsp_s and the state enum shall live in shared package arb_pkg.
REQ-029 Winner selection shall be a sub-module rr_arbiter2 (two valids + last_grant -> one-hot grant); rest is flat.

Verification
REQ-030 Port 1 read addr 0x100, gnt same cycle, rvalid next with 0xDEADBEEF -> rsp_o[1].rvalid one cycle, rdata 0xDEADBEEF, rsp_o[0] silent.
REQ-031 Both ports valid every cycle for 6 transactions after reset -> grant order 0,1,0,1,0,1.
REQ-032 Port 0 write strb 4'b0011 addr 0x204, gnt withheld 5 cycles -> mem_req_o held stable, ack rvalid with rdata 0.
REQ-033 No rvalid after gnt, TIMEOUT=8 -> rvalid with err = 1 eight cycles after handshake, err_o = 1, next request accepted.
REQ-034 rvalid pulsed in IDLE -> err_o = 1, no requester rvalid.
REQ-035 rst_ni low during WAIT_RSP, then late rvalid -> no response, all outputs 0, next handshake grants port 0 on tie.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Holds the requester/memory request and response structs, the arbiter
// state encoding and the default bus widths the structs are sized with.
package arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    // Requester -> arbiter request.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_STRB_W-1:0] strb;
    } arb_req_s;

    // Arbiter -> requester response.
    typedef struct packed {
        logic                  ready;
        logic                  rvalid;
        logic                  err;
        logic [ARB_DATA_W-1:0] rdata;
    } arb_rsp_s;

    // Arbiter -> memory request.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_STRB_W-1:0] strb;
    } arb_mem_req_s;

    // Memory -> arbiter response.
    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [ARB_DATA_W-1:0] rdata;
    } arb_mem_rsp_s;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin winner selection.
// Ports:
//   valid_i      - request valids, bit n = port n
//   last_grant_i - port id that won the previous arbitration
//   grant_o      - one-hot winner (all-zero when nobody requests)
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // Lone requester wins outright; on a tie the port not granted last wins.
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter (port 0 = fetch, port 1 = LSU) with a single
// outstanding transaction, round-robin tie-breaking, a transaction timeout
// and a sticky protocol-error flag.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   req_i[0:1]    - requester requests {valid, we, addr, wdata, strb}
//   rsp_o[0:1]    - requester responses {ready, rvalid, err, rdata}
//   mem_req_o     - memory request {valid, we, addr, wdata, strb}
//   mem_rsp_i     - memory response {gnt, rvalid, rdata}
//   err_o         - sticky error: stray gnt/rvalid or timeout
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  arb_req_s     req_i [0:1],
    output arb_rsp_s     rsp_o [0:1],
    output arb_mem_req_s mem_req_o,
    input  arb_mem_rsp_s mem_rsp_i,
    output logic         err_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic                    r_owner;
    logic                    r_last_grant;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_strb;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;

    logic [1:0]              w_valid;
    logic [1:0]              w_grant;
    logic                    w_idle;
    logic                    w_busy;
    logic                    w_hs;
    logic                    w_cnt_max;
    logic                    w_proto_err;
    logic                    w_tmo_fire;
    logic                    w_rsp_valid;
    logic                    w_rsp_err;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata;
    arb_req_s                w_win_req;

    assign w_valid   = {req_i[1].valid, req_i[0].valid};
    assign w_idle    = (r_state == ST_IDLE);
    assign w_busy    = (r_state == ST_ISSUE) || (r_state == ST_WAIT_RSP);
    // The arbiter only grants valid ports, so a grant in IDLE is the handshake.
    assign w_hs      = w_idle && (w_grant != 2'b00);
    assign w_win_req = w_grant[1] ? req_i[1] : req_i[0];
    assign w_cnt_max = w_busy && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_proto_err = (mem_rsp_i.rvalid && (r_state != ST_WAIT_RSP)) ||
                         (mem_rsp_i.gnt    && (r_state != ST_ISSUE));
    assign err_o     = r_err;

    rr_arbiter2 u_rr_arbiter2 (
        .valid_i      (w_valid),
        .last_grant_i (r_last_grant),
        .grant_o      (w_grant)
    );

    // Next state and the response that completes the current transaction.
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = '0;
        w_tmo_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_cnt_max) begin
                    w_state_nxt = ST_IDLE;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_tmo_fire  = 1'b1;
                end else if (mem_rsp_i.gnt) begin
                    w_state_nxt = ST_WAIT_RSP;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_WAIT_RSP: begin
                // A real response beats a timeout landing in the same cycle.
                if (mem_rsp_i.rvalid) begin
                    w_state_nxt = ST_IDLE;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = r_we ? '0 : mem_rsp_i.rdata;
                end else if (w_cnt_max) begin
                    w_state_nxt = ST_IDLE;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_tmo_fire  = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT_RSP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-port responses: ready to the IDLE winner, completion to the owner only.
    for (genvar p = 0; p < 2; p++) begin : g_rsp
        always_comb begin
            rsp_o[p].ready = w_idle && w_grant[p];
            if (w_rsp_valid && (r_owner == 1'(p))) begin
                rsp_o[p].rvalid = 1'b1;
                rsp_o[p].err    = w_rsp_err;
                rsp_o[p].rdata  = w_rsp_rdata;
            end else begin
                rsp_o[p].rvalid = 1'b0;
                rsp_o[p].err    = 1'b0;
                rsp_o[p].rdata  = '0;
            end
        end
    end

    // Memory request driven from the captured fields only while issuing.
    always_comb begin
        if (r_state == ST_ISSUE) begin
            mem_req_o.valid = 1'b1;
            mem_req_o.we    = r_we;
            mem_req_o.addr  = r_addr;
            mem_req_o.wdata = r_wdata;
            mem_req_o.strb  = r_strb;
        end else begin
            mem_req_o = '0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winning request and remember who won for round-robin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_strb       <= '0;
        end else if (w_hs) begin
            r_owner      <= w_grant[1];
            r_last_grant <= w_grant[1];
            r_we         <= w_win_req.we;
            r_addr       <= w_win_req.addr;
            r_wdata      <= w_win_req.wdata;
            r_strb       <= w_win_req.strb;
        end
    end

    // Timeout counter: cleared on handshake, counts while a transaction is open.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_hs) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_proto_err || w_tmo_fire) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: requester drivers, a memory
// responder and a scoreboard of expected responses, all advanced once per
// clock; scenario tasks push requests/expectations and check inline.
module tb_mem_arbiter;
    import arb_pkg::*;

    localparam int TMO = 8;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    arb_req_s     req0 = '0;
    arb_req_s     req1 = '0;
    arb_req_s     req_arr [0:1];
    arb_rsp_s     rsp_arr [0:1];
    arb_mem_req_s mem_req;
    arb_mem_rsp_s mem_rsp = '0;
    logic         err_o;

    exp_t         exp_q [$];
    arb_req_s     q0 [$];
    arb_req_s     q1 [$];
    exp_t         e_mon;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           hs_cyc [2];
    bit           hs0 = 1'b0;
    bit           hs1 = 1'b0;
    int           gnt_wait = 0;
    bit           drop = 1'b0;
    int           frv_req = 0, frv_done = 0;
    int           fg_req = 0, fg_done = 0;
    bit           pend = 1'b0;
    logic [31:0]  pend_data = 32'h0;
    int           wcnt = 0;

    assign req_arr[0] = req0;
    assign req_arr[1] = req1;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .req_i     (req_arr),
        .rsp_o     (rsp_arr),
        .mem_req_o (mem_req),
        .mem_rsp_i (mem_rsp),
        .err_o     (err_o)
    );

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return 32'hDEAD_BEEF ^ (a - 32'h0000_0100);
    endfunction

    function automatic arb_req_s mk_req(input logic we, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] st);
        arb_req_s r;
        r.valid = 1'b1; r.we = we; r.addr = a; r.wdata = wd; r.strb = st;
        return r;
    endfunction

    function automatic exp_t mk_exp(input int p, input logic we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] st,
                                    input logic er, input logic [31:0] rd, input int lat);
        exp_t e;
        e.port = p; e.we = we; e.addr = a; e.wdata = wd; e.strb = st;
        e.err = er; e.rdata = rd; e.lat = lat;
        return e;
    endfunction

    // Per-cycle machinery: requester drivers, memory responder, scoreboard monitor.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        hs0 = 1'b0;
        hs1 = 1'b0;
        req0 = (q0.size() > 0) ? q0[0] : '0;
        req1 = (q1.size() > 0) ? q1[0] : '0;
        #1;
        mem_rsp = '0;
        if (!rst_ni) begin
            pend = 1'b0;
            wcnt = 0;
        end
        if (frv_req != frv_done) begin
            mem_rsp.rvalid = 1'b1;
            mem_rsp.rdata  = 32'h1234_5678;
            frv_done = frv_req;
        end else if (fg_req != fg_done) begin
            mem_rsp.gnt = 1'b1;
            fg_done = fg_req;
        end else if (pend) begin
            mem_rsp.rvalid = 1'b1;
            mem_rsp.rdata  = pend_data;
            pend = 1'b0;
        end else if (rst_ni && mem_req.valid) begin
            if (wcnt >= gnt_wait) begin
                mem_rsp.gnt = 1'b1;
                wcnt = 0;
                if (!drop) begin
                    pend = 1'b1;
                    pend_data = mem_req.we ? 32'hBAD0_BAD0 : mem_model(mem_req.addr);
                end
            end else begin
                wcnt++;
            end
        end
        @(negedge clk);
        if (rst_ni) begin
            if (rsp_arr[0].ready && req0.valid) begin hs0 = 1'b1; hs_cyc[0] = cyc; end
            if (rsp_arr[1].ready && req1.valid) begin hs1 = 1'b1; hs_cyc[1] = cyc; end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (rsp_arr[p].rvalid) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rvalid port %0d: got rvalid=1 err=%0b rdata=%h, want no response",
                                 p, rsp_arr[p].err, rsp_arr[p].rdata);
                    end else begin
                        e_mon = exp_q.pop_front();
                        if (e_mon.port != p || rsp_arr[p].err !== e_mon.err || rsp_arr[p].rdata !== e_mon.rdata) begin
                            errors++;
                            $display("FAIL rsp_mismatch: got port %0d err=%0b rdata=%h, want port %0d err=%0b rdata=%h",
                                     p, rsp_arr[p].err, rsp_arr[p].rdata, e_mon.port, e_mon.err, e_mon.rdata);
                        end
                        if (e_mon.lat > 0) begin
                            checks++;
                            if (cyc - hs_cyc[p] != e_mon.lat) begin
                                errors++;
                                $display("FAIL latency port %0d: got %0d cycles, want %0d",
                                         p, cyc - hs_cyc[p], e_mon.lat);
                            end
                        end
                    end
                end else if (rsp_arr[p].rdata !== 32'h0 || rsp_arr[p].err !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_rsp port %0d: got err=%0b rdata=%h, want 0/0",
                             p, rsp_arr[p].err, rsp_arr[p].rdata);
                end
            end
            if (mem_req.valid) begin
                if (exp_q.size() > 0) begin
                    checks++;
                    if (mem_req.we !== exp_q[0].we || mem_req.addr !== exp_q[0].addr ||
                        mem_req.wdata !== exp_q[0].wdata || mem_req.strb !== exp_q[0].strb) begin
                        errors++;
                        $display("FAIL mem_req: got we=%0b addr=%h wdata=%h strb=%h, want we=%0b addr=%h wdata=%h strb=%h",
                                 mem_req.we, mem_req.addr, mem_req.wdata, mem_req.strb,
                                 exp_q[0].we, exp_q[0].addr, exp_q[0].wdata, exp_q[0].strb);
                    end
                end
            end else begin
                checks++;
                if (mem_req !== '0) begin
                    errors++;
                    $display("FAIL mem_idle: got %h, want all zero", mem_req);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        exp_q.delete();
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: got %0d responses outstanding after %0d cycles, want 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_err(input logic want, input string name);
        checks++;
        if (err_o !== want) begin
            errors++;
            $display("FAIL %s: got err_o=%0b, want %0b", name, err_o, want);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_arr[0] !== '0 || rsp_arr[1] !== '0 || mem_req !== '0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rsp0=%h rsp1=%h mem=%h err=%0b, want all zero",
                     rsp_arr[0], rsp_arr[1], mem_req, err_o);
        end
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        exp_q.push_back(mk_exp(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 2));
        q1.push_back(mk_req(1'b0, 32'h0000_0100, 32'h0, 4'hF));
        wait_done(40, "single_read");
        check_err(1'b0, "single_read_err");
    endtask

    task automatic test_round_robin();
        logic [31:0] a0, a1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a0 = 32'h0000_1000 + 32'(k * 16);
            a1 = 32'h0000_2000 + 32'(k * 16);
            q0.push_back(mk_req(1'b0, a0, 32'h0, 4'hF));
            q1.push_back(mk_req(1'b0, a1, 32'h0, 4'hF));
            exp_q.push_back(mk_exp(0, 1'b0, a0, 32'h0, 4'hF, 1'b0, mem_model(a0), 0));
            exp_q.push_back(mk_exp(1, 1'b0, a1, 32'h0, 4'hF, 1'b0, mem_model(a1), 0));
        end
        wait_done(100, "round_robin");
    endtask

    task automatic test_write_stall();
        gnt_wait = 5;
        exp_q.push_back(mk_exp(0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'b0011, 1'b0, 32'h0, 7));
        q0.push_back(mk_req(1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'b0011));
        wait_done(40, "write_stall");
        gnt_wait = 0;
        check_err(1'b0, "write_stall_err");
    endtask

    task automatic test_timeout();
        drop = 1'b1;
        exp_q.push_back(mk_exp(1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b1, 32'h0, TMO));
        q1.push_back(mk_req(1'b0, 32'h0000_0300, 32'h0, 4'hF));
        wait_done(40, "timeout");
        drop = 1'b0;
        check_err(1'b1, "timeout_err");
        exp_q.push_back(mk_exp(0, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 1'b0, mem_model(32'h0000_0400), 2));
        q0.push_back(mk_req(1'b0, 32'h0000_0400, 32'h0, 4'hF));
        wait_done(40, "after_timeout");
        check_err(1'b1, "err_sticky");
    endtask

    task automatic test_protocol_err();
        do_reset();
        check_err(1'b0, "proto_err_clear");
        frv_req++;
        @(negedge clk);
        checks++;
        if ((rsp_arr[0].rvalid | rsp_arr[1].rvalid) !== 1'b0) begin
            errors++;
            $display("FAIL idle_rvalid_forward: got rvalid %0b/%0b, want 0/0",
                     rsp_arr[0].rvalid, rsp_arr[1].rvalid);
        end
        @(negedge clk);
        check_err(1'b1, "idle_rvalid_err");
        do_reset();
        fg_req++;
        repeat (2) @(negedge clk);
        check_err(1'b1, "idle_gnt_err");
        do_reset();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        drop = 1'b1;
        q1.push_back(mk_req(1'b0, 32'h0000_0500, 32'h0, 4'hF));
        while (!(mem_req.valid && mem_rsp.gnt) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL reset_mid_gnt: got no granted mem request within 20 cycles, want one");
        end
        @(negedge clk);
        rst_ni = 1'b0;
        exp_q.delete();
        q0.delete();
        q1.delete();
        drop = 1'b0;
        frv_req++;
        @(negedge clk);
        checks++;
        if (rsp_arr[0] !== '0 || rsp_arr[1] !== '0 || mem_req !== '0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got rsp0=%h rsp1=%h mem=%h err=%0b, want all zero",
                     rsp_arr[0], rsp_arr[1], mem_req, err_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        exp_q.push_back(mk_exp(0, 1'b0, 32'h0000_0600, 32'h0, 4'hF, 1'b0, mem_model(32'h0000_0600), 2));
        exp_q.push_back(mk_exp(1, 1'b0, 32'h0000_0700, 32'h0, 4'hF, 1'b0, mem_model(32'h0000_0700), 0));
        q0.push_back(mk_req(1'b0, 32'h0000_0600, 32'h0, 4'hF));
        q1.push_back(mk_req(1'b0, 32'h0000_0700, 32'h0, 4'hF));
        wait_done(40, "reset_mid_next");
        check_err(1'b0, "reset_mid_err");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stall();
        test_timeout();
        test_protocol_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
